// File: rtl/mac_mult_arbiter.sv
// Round-robin arbiter feeding a two-stage shared mini-float multiplier:
// S1 holds the granted operands, S2 holds the registered product.
module mac_mult_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    i_valid,
    output logic [N_REQ-1:0]    o_ready,
    input  logic [N_REQ*10-1:0] i_a,
    input  logic [N_REQ*10-1:0] i_b,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [ID_W-1:0]     o_id,
    output logic                o_sign,
    output logic [4:0]          o_exp,
    output logic [9:0]          o_mant,
    output logic                o_busy
);

    // Handshake: a beat moves on a rising edge where valid and ready are both
    // high; ready never looks at the payload, and a stalled payload holds.

    logic [9:0]      a_arr [N_REQ];
    logic [9:0]      b_arr [N_REQ];

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [9:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic            s2_valid_q, s2_valid_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic            s2_sign_q, s2_sign_d;
    logic [4:0]      s2_exp_q, s2_exp_d;
    logic [9:0]      s2_mant_q, s2_mant_d;

    logic            grant_hit;
    logic [ID_W-1:0] grant_id, cand;
    logic            s1_adv, s2_adv, xfer;
    logic            prod_sign;
    logic [4:0]      prod_exp;
    logic [9:0]      prod_mant;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign a_arr[k] = i_a[k*10 +: 10];
        assign b_arr[k] = i_b[k*10 +: 10];
    end

    // ptr_q is the requester with top priority this cycle.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!grant_hit && i_valid[cand]) begin
                grant_hit = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign s2_adv = !s2_valid_q || i_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign xfer   = grant_hit && s1_adv && !rst;

    always_comb begin
        o_ready = '0;
        if (xfer) o_ready[grant_id] = 1'b1;
    end

    assign prod_sign = s1_a_q[9] ^ s1_b_q[9];
    assign prod_exp  = {1'b0, s1_a_q[8:5]} + {1'b0, s1_b_q[8:5]};
    assign prod_mant = {5'd0, s1_a_q[4:0]} * {5'd0, s1_b_q[4:0]};

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_mant_d  = s2_mant_q;
        if (xfer) begin
            ptr_d = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
        end
        if (s1_adv) begin
            s1_valid_d = xfer;
            if (xfer) begin
                s1_id_d = grant_id;
                s1_a_d  = a_arr[grant_id];
                s1_b_d  = b_arr[grant_id];
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_id_d   = s1_id_q;
                s2_sign_d = prod_sign;
                s2_exp_d  = prod_exp;
                s2_mant_d = prod_mant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_mant_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_sign_q  <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;
            s2_mant_q  <= s2_mant_d;
        end
    end

    assign o_valid = s2_valid_q;
    assign o_id    = s2_id_q;
    assign o_sign  = s2_sign_q;
    assign o_exp   = s2_exp_q;
    assign o_mant  = s2_mant_q;
    assign o_busy  = s1_valid_q | s2_valid_q;

endmodule
